// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight writers in EX/MEM/WB and stalls
// the ID instruction when forwarding cannot deliver its source operands in time.
module hazard_scoreboard #(
    parameter bit FORWARDING   = 1'b1,
    parameter bit REG_WR_FIRST = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic [4:0]       id_dest,
    input  logic             flush,
    output logic             stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             hazard_rs,
    output logic             hazard_rt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       v;
        logic       wr;
        logic       ld;
        logic [4:0] dest;
    } entry_t;

    entry_t ex_q, mem_q, wb_q;
    entry_t ex_d;
    logic   rs_match, rt_match;

    // need_ld restricts the match to loads, which is the only case forwarding cannot cover
    function automatic logic writes_reg(entry_t e, logic [4:0] r, logic need_ld);
        return e.v && e.wr && (e.ld || !need_ld) && (e.dest != 5'd0) && (e.dest == r);
    endfunction

    always_comb begin
        rs_match = 1'b0;
        rt_match = 1'b0;
        if (FORWARDING) begin
            rs_match = writes_reg(ex_q, id_rs, 1'b1);
            rt_match = writes_reg(ex_q, id_rt, 1'b1);
        end else begin
            rs_match = writes_reg(ex_q, id_rs, 1'b0) || writes_reg(mem_q, id_rs, 1'b0)
                    || (!REG_WR_FIRST && writes_reg(wb_q, id_rs, 1'b0));
            rt_match = writes_reg(ex_q, id_rt, 1'b0) || writes_reg(mem_q, id_rt, 1'b0)
                    || (!REG_WR_FIRST && writes_reg(wb_q, id_rt, 1'b0));
        end
    end

    always_comb begin
        hazard_rs   = id_valid && id_use_rs && rs_match;
        hazard_rt   = id_valid && id_use_rt && rt_match;
        stall       = (hazard_rs || hazard_rt) && !flush;
        pc_write    = !stall;
        ifid_write  = !stall;
        idex_bubble = stall || flush;
        ex_d        = '0;
        if (!idex_bubble) begin
            ex_d = '{v: id_valid, wr: id_reg_write, ld: id_mem_read, dest: id_dest};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: four configurations driven by one
// instruction stream, each checked against an age-based model of in-flight writers.
module tb_hazard_scoreboard;

    typedef struct packed {
        logic       v;
        logic       wr;
        logic       ld;
        logic [4:0] dest;
    } instr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;

    logic [3:0]  stall_v, pcw_v, ifw_v, bub_v, hrs_v, hrt_v;
    logic [15:0] cnt_v [4];
    logic [15:0] cnt0, cnt1, cnt2;
    logic [1:0]  cnt3;

    int vectors = 0;
    int miscompares = 0;

    instr_t mslot [4][3];
    int     mcnt [4];
    bit     es [4], ehrs [4], ehrt [4];
    int     stallSeen [4];
    int     satSeq [5] = '{1, 2, 3, 3, 3};

    always #5 clk = ~clk;

    assign cnt_v[0] = cnt0;
    assign cnt_v[1] = cnt1;
    assign cnt_v[2] = cnt2;
    assign cnt_v[3] = {14'b0, cnt3};

    hazard_scoreboard #(.FORWARDING(1'b1), .REG_WR_FIRST(1'b1), .CNT_W(16)) u_f1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_dest(id_dest), .flush(flush),
        .stall(stall_v[0]), .pc_write(pcw_v[0]), .ifid_write(ifw_v[0]),
        .idex_bubble(bub_v[0]), .hazard_rs(hrs_v[0]), .hazard_rt(hrt_v[0]), .stall_cnt(cnt0));

    hazard_scoreboard #(.FORWARDING(1'b0), .REG_WR_FIRST(1'b1), .CNT_W(16)) u_f0w1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_dest(id_dest), .flush(flush),
        .stall(stall_v[1]), .pc_write(pcw_v[1]), .ifid_write(ifw_v[1]),
        .idex_bubble(bub_v[1]), .hazard_rs(hrs_v[1]), .hazard_rt(hrt_v[1]), .stall_cnt(cnt1));

    hazard_scoreboard #(.FORWARDING(1'b0), .REG_WR_FIRST(1'b0), .CNT_W(16)) u_f0w0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_dest(id_dest), .flush(flush),
        .stall(stall_v[2]), .pc_write(pcw_v[2]), .ifid_write(ifw_v[2]),
        .idex_bubble(bub_v[2]), .hazard_rs(hrs_v[2]), .hazard_rt(hrt_v[2]), .stall_cnt(cnt2));

    hazard_scoreboard #(.FORWARDING(1'b1), .REG_WR_FIRST(1'b1), .CNT_W(2)) u_f1c2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_dest(id_dest), .flush(flush),
        .stall(stall_v[3]), .pc_write(pcw_v[3]), .ifid_write(ifw_v[3]),
        .idex_bubble(bub_v[3]), .hazard_rs(hrs_v[3]), .hazard_rt(hrt_v[3]), .stall_cnt(cnt3));

    function automatic bit fwdOf(int m);
        return (m == 0) || (m == 3);
    endfunction

    function automatic bit wrFirstOf(int m);
        return m != 2;
    endfunction

    function automatic int cntMaxOf(int m);
        return (m == 3) ? 3 : 65535;
    endfunction

    // A writer issued `age` cycles ago (0 = now in EX) is still a hazard if its result
    // cannot reach ID in time: loads one cycle back with forwarding, otherwise anything
    // younger than the register-file write point.
    function automatic bit modelHit(int m, logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        for (int age = 0; age < 3; age++) begin
            if (mslot[m][age].v && mslot[m][age].wr && mslot[m][age].dest == r) begin
                if (fwdOf(m)) begin
                    if (age == 0 && mslot[m][age].ld) return 1'b1;
                end else if (age < (wrFirstOf(m) ? 2 : 3)) begin
                    return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    function automatic void modelEval();
        for (int m = 0; m < 4; m++) begin
            ehrs[m] = id_valid && id_use_rs && modelHit(m, id_rs);
            ehrt[m] = id_valid && id_use_rt && modelHit(m, id_rt);
            es[m]   = (ehrs[m] || ehrt[m]) && !flush;
        end
    endfunction

    function automatic void modelAdvance();
        instr_t issued;
        for (int m = 0; m < 4; m++) begin
            issued = (es[m] || flush) ? '0 : '{id_valid, id_reg_write, id_mem_read, id_dest};
            mslot[m][2] = mslot[m][1];
            mslot[m][1] = mslot[m][0];
            mslot[m][0] = issued;
            if (es[m] && mcnt[m] < cntMaxOf(m)) mcnt[m]++;
        end
    endfunction

    function automatic void modelReset();
        for (int m = 0; m < 4; m++) begin
            for (int a = 0; a < 3; a++) mslot[m][a] = '0;
            mcnt[m] = 0;
        end
    endfunction

    task automatic chkBit(input string tag, input int m, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s inst%0d observed=%0b expected=%0b", tag, m, obs, exp);
        end
    endtask

    task automatic chkVal(input string tag, input int m, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s inst%0d observed=%0d expected=%0d", tag, m, obs, exp);
        end
    endtask

    task automatic checkOutput();
        for (int m = 0; m < 4; m++) begin
            chkBit("stall", m, stall_v[m], es[m]);
            chkBit("hazard_rs", m, hrs_v[m], ehrs[m]);
            chkBit("hazard_rt", m, hrt_v[m], ehrt[m]);
            chkBit("pc_write", m, pcw_v[m], !es[m]);
            chkBit("ifid_write", m, ifw_v[m], !es[m]);
            chkBit("idex_bubble", m, bub_v[m], es[m] || flush);
            chkVal("stall_cnt", m, cnt_v[m], 16'(mcnt[m]));
            if (stall_v[m] === 1'b1) stallSeen[m]++;
        end
    endtask

    task automatic checkReset();
        for (int m = 0; m < 4; m++) begin
            chkBit("rst_stall", m, stall_v[m], 1'b0);
            chkBit("rst_hazard_rs", m, hrs_v[m], 1'b0);
            chkBit("rst_hazard_rt", m, hrt_v[m], 1'b0);
            chkBit("rst_pc_write", m, pcw_v[m], 1'b1);
            chkBit("rst_ifid_write", m, ifw_v[m], 1'b1);
            chkBit("rst_idex_bubble", m, bub_v[m], flush);
            chkVal("rst_stall_cnt", m, cnt_v[m], 16'd0);
        end
    endtask

    // Inputs are already set; check mid-cycle, then clock the DUTs and the model together
    task automatic applyStimulus();
        #1;
        modelEval();
        checkOutput();
        @(posedge clk);
        modelAdvance();
        #1;
    endtask

    task automatic setInstr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic urs, input logic urt, input logic rw,
                            input logic mr, input logic [4:0] dest, input logic fl);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_reg_write = rw; id_mem_read = mr; id_dest = dest; flush = fl;
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) begin
            setInstr(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
            applyStimulus();
        end
    endtask

    task automatic clearSeen();
        for (int m = 0; m < 4; m++) stallSeen[m] = 0;
    endtask

    initial begin
        modelReset();
        clearSeen();
        #12;
        checkReset();
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] load-use and RAW stall lengths");
        setInstr(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
        applyStimulus();
        clearSeen();
        for (int i = 0; i < 4; i++) begin
            setInstr(1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0);
            applyStimulus();
        end
        chkVal("lw_use_len", 0, 16'(stallSeen[0]), 16'd1);
        chkVal("lw_use_len", 1, 16'(stallSeen[1]), 16'd2);
        chkVal("lw_use_len", 2, 16'(stallSeen[2]), 16'd3);
        chkVal("lw_use_cnt", 0, cnt_v[0], 16'd1);
        bubbles(3);

        setInstr(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0);
        applyStimulus();
        clearSeen();
        for (int i = 0; i < 4; i++) begin
            setInstr(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0);
            applyStimulus();
        end
        chkVal("alu_fwd_len", 0, 16'(stallSeen[0]), 16'd0);
        bubbles(3);

        setInstr(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
        applyStimulus();
        clearSeen();
        for (int i = 0; i < 3; i++) begin
            setInstr(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0);
            applyStimulus();
        end
        for (int m = 0; m < 4; m++) chkVal("reg0_len", m, 16'(stallSeen[m]), 16'd0);
        bubbles(3);

        setInstr(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0);
        applyStimulus();
        clearSeen();
        for (int i = 0; i < 4; i++) begin
            setInstr(1'b1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0);
            applyStimulus();
        end
        chkVal("raw_len", 0, 16'(stallSeen[0]), 16'd0);
        chkVal("raw_len", 1, 16'(stallSeen[1]), 16'd2);
        chkVal("raw_len", 2, 16'(stallSeen[2]), 16'd3);
        bubbles(3);

        $display("[TB] flush squashes the ID instruction");
        setInstr(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0);
        applyStimulus();
        setInstr(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1);
        #1;
        chkVal("flush_stall", -1, {12'b0, stall_v}, 16'h0);
        chkVal("flush_bubble", -1, {12'b0, bub_v}, 16'hF);
        applyStimulus();
        clearSeen();
        setInstr(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 1'b0);
        applyStimulus();
        for (int m = 0; m < 4; m++) chkVal("post_flush_len", m, 16'(stallSeen[m]), 16'd0);
        bubbles(3);

        $display("[TB] asynchronous reset with a load in EX");
        setInstr(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
        applyStimulus();
        setInstr(1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0);
        #1;
        chkBit("pre_rst_stall", 0, stall_v[0], 1'b1);
        rst = 1'b0;
        #1;
        modelReset();
        checkReset();
        rst = 1'b1;
        clearSeen();
        applyStimulus();
        for (int m = 0; m < 4; m++) chkVal("post_rst_len", m, 16'(stallSeen[m]), 16'd0);
        bubbles(3);

        $display("[TB] counter saturation");
        for (int k = 0; k < 5; k++) begin
            setInstr(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
            applyStimulus();
            for (int i = 0; i < 2; i++) begin
                setInstr(1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0);
                applyStimulus();
            end
            chkVal("sat_cnt", 3, cnt_v[3], 16'(satSeq[k]));
            bubbles(2);
        end

        $display("[TB] randomized stream");
        for (int i = 0; i < 400; i++) begin
            setInstr($urandom_range(0, 9) != 0, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                     1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     5'($urandom_range(0, 5)), $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) == 0) begin
                #1;
                rst = 1'b0;
                #1;
                modelReset();
                checkReset();
                rst = 1'b1;
            end
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
